// File: rtl/vga_sync_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_sync_monitor                                             |
// | Description : Receive-side VGA timing monitor. Registers hsync/vsync/rgb,  |
// |               locks a local x/y counter to the incoming sync pulses,       |
// |               reports timing errors and decodes the platform band (first   |
// |               contiguous run of all-PLAT_RGB active rows) per frame.       |
// | Ports       : clk, reset (sync, active-high)                               |
// |               hsync_in/vsync_in (active-low), rgb_in[2:0]                  |
// |               pix_x/pix_y/active : coordinates of the sampled pixel        |
// |               locked, sync_err, frame_done : status / pulses               |
// |               plat_start/plat_end/plat_valid : last decoded band           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vga_sync_monitor #(
    parameter int         H_ACTIVE     = 640,
    parameter int         H_TOTAL      = 800,
    parameter int         H_SYNC_START = 656,
    parameter int         H_SYNC_END   = 752,
    parameter int         V_ACTIVE     = 480,
    parameter int         V_TOTAL      = 525,
    parameter int         V_SYNC_START = 490,
    parameter int         LOCK_FRAMES  = 2,
    parameter logic [2:0] PLAT_RGB     = 3'b100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [2:0] rgb_in,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       active,
    output logic       locked,
    output logic       sync_err,
    output logic       frame_done,
    output logic [9:0] plat_start,
    output logic [9:0] plat_end,
    output logic       plat_valid
);

    localparam logic [9:0] c_H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_HS_START   = 10'(H_SYNC_START);
    localparam logic [9:0] c_HS_END     = 10'(H_SYNC_END);
    // Pixel following the hsync fall: both the load value after a fall and
    // the point where a missing fall is declared.
    localparam logic [9:0] c_HS_AFTER   = 10'(H_SYNC_START + 1);
    localparam logic [9:0] c_VS_START   = 10'(V_SYNC_START);
    localparam logic [9:0] c_H_ACTIVE   = 10'(H_ACTIVE);
    localparam logic [9:0] c_V_ACTIVE   = 10'(V_ACTIVE);
    localparam logic [9:0] c_X_ACT_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] c_Y_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [3:0] c_LOCK       = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t     r_state, w_state_next;
    logic       r_hs_q, r_hs_q2, r_vs_q, r_vs_q2;
    logic [2:0] r_rgb_q;
    logic [9:0] r_x, r_y, w_x_inc, w_y_inc, w_x_next, w_y_next;
    logic [3:0] r_good, w_good_next, w_good_inc;
    logic       r_clean, w_clean_next;
    logic       r_hs_seen, r_row_ok;
    logic       r_found, r_closed, w_found_next, w_closed_next;
    logic [9:0] r_start_cap, r_end_cap, w_start_next, w_end_next;
    logic       r_active, r_locked, r_sync_err, r_frame_done, r_plat_valid;
    logic [9:0] r_plat_start, r_plat_end;
    logic       w_hs_fall, w_hs_rise, w_vs_fall, w_mismatch;
    logic       w_pix_plat, w_row_plat, w_decode, w_eol, w_eof, w_frame_end;

    // Input sample stage plus a second stage for edge detection. Sync lines
    // reset to their idle (high) level so no edge is seen right after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hs_q  <= 1'b1;
            r_hs_q2 <= 1'b1;
            r_vs_q  <= 1'b1;
            r_vs_q2 <= 1'b1;
            r_rgb_q <= 3'd0;
        end else begin
            r_hs_q  <= hsync_in;
            r_hs_q2 <= r_hs_q;
            r_vs_q  <= vsync_in;
            r_vs_q2 <= r_vs_q;
            r_rgb_q <= rgb_in;
        end
    end

    assign w_hs_fall = r_hs_q2 & ~r_hs_q;
    assign w_hs_rise = ~r_hs_q2 & r_hs_q;
    assign w_vs_fall = r_vs_q2 & ~r_vs_q;

    // r_x/r_y describe the pixel in the sample stage. An edge is seen in the
    // cycle its first pixel sits in that stage, so a load realigns the
    // counter to the pixel after the sync position.
    always_comb begin
        w_x_inc = (r_x == c_H_LAST) ? 10'd0 : r_x + 10'd1;
        w_y_inc = r_y;
        if (r_x == c_H_LAST) begin
            w_y_inc = (r_y == c_V_LAST) ? 10'd0 : r_y + 10'd1;
        end
        w_x_next = w_x_inc;
        w_y_next = w_y_inc;
        if (w_vs_fall) begin
            w_x_next = 10'd1;
            w_y_next = c_VS_START;
        end else if (w_hs_fall) begin
            w_x_next = c_HS_AFTER;
            w_y_next = r_y;
        end
    end

    assign w_mismatch = (w_hs_fall && (r_x != c_HS_START))
                     || (w_hs_rise && (r_x != c_HS_END))
                     || (w_vs_fall && ((r_x != 10'd0) || (r_y != c_VS_START)))
                     || ((r_x == c_HS_AFTER) && !r_hs_seen && !w_hs_fall);

    assign w_good_inc = r_good + 4'd1;

    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good;
        w_clean_next = r_clean;
        case (r_state)
            ST_SEARCH: begin
                if (w_vs_fall) begin
                    w_state_next = ST_ALIGN;
                    w_good_next  = 4'd0;
                    w_clean_next = 1'b1;
                end
            end
            ST_ALIGN: begin
                if (w_mismatch) begin
                    w_good_next  = 4'd0;
                    w_clean_next = 1'b0;
                end else if (w_vs_fall) begin
                    w_clean_next = 1'b1;
                    if (r_clean) begin
                        if (w_good_inc == c_LOCK) begin
                            w_state_next = ST_LOCKED;
                            w_good_next  = 4'd0;
                        end else begin
                            w_good_next = w_good_inc;
                        end
                    end
                end
            end
            ST_LOCKED: begin
                if (w_mismatch) begin
                    w_state_next = ST_SEARCH;
                    w_good_next  = 4'd0;
                    w_clean_next = 1'b0;
                end
            end
            default: begin
                w_state_next = ST_SEARCH;
                w_good_next  = 4'd0;
                w_clean_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_SEARCH;
            r_good    <= 4'd0;
            r_clean   <= 1'b0;
            r_x       <= 10'd0;
            r_y       <= 10'd0;
            r_hs_seen <= 1'b0;
            r_row_ok  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_good  <= w_good_next;
            r_clean <= w_clean_next;
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            if (w_hs_fall) begin
                r_hs_seen <= 1'b1;
            end else if (w_vs_fall || (r_x == c_H_LAST)) begin
                r_hs_seen <= 1'b0;
            end
            // Running AND of "pixel is platform colour" across the active row.
            if (r_x == 10'd0) begin
                r_row_ok <= w_pix_plat;
            end else if (r_x < c_H_ACTIVE) begin
                r_row_ok <= r_row_ok & w_pix_plat;
            end
        end
    end

    // Platform band decode; a mismatch cycle is treated as out of lock.
    assign w_pix_plat  = (r_rgb_q == PLAT_RGB);
    assign w_row_plat  = r_row_ok & w_pix_plat;
    assign w_decode    = (r_state == ST_LOCKED) && !w_mismatch;
    assign w_eol       = (r_x == c_X_ACT_LAST) && (r_y < c_V_ACTIVE);
    assign w_eof       = (r_x == c_X_ACT_LAST) && (r_y == c_Y_ACT_LAST);
    assign w_frame_end = w_decode && w_eof;

    always_comb begin
        w_found_next  = r_found;
        w_closed_next = r_closed;
        w_start_next  = r_start_cap;
        w_end_next    = r_end_cap;
        if (!w_decode) begin
            w_found_next  = 1'b0;
            w_closed_next = 1'b0;
        end else if (w_eol) begin
            if (!r_found && w_row_plat) begin
                w_found_next = 1'b1;
                w_start_next = r_y;
            end else if (r_found && !r_closed && !w_row_plat) begin
                w_closed_next = 1'b1;
                w_end_next    = r_y;
            end
        end
        // Band still open at the last active row: it ends at the frame edge.
        if (w_frame_end && w_found_next && !w_closed_next) begin
            w_end_next = c_V_ACTIVE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_found      <= 1'b0;
            r_closed     <= 1'b0;
            r_start_cap  <= 10'd0;
            r_end_cap    <= 10'd0;
            r_active     <= 1'b0;
            r_locked     <= 1'b0;
            r_sync_err   <= 1'b0;
            r_frame_done <= 1'b0;
            r_plat_valid <= 1'b0;
            r_plat_start <= 10'd0;
            r_plat_end   <= 10'd0;
        end else begin
            r_found      <= w_frame_end ? 1'b0 : w_found_next;
            r_closed     <= w_frame_end ? 1'b0 : w_closed_next;
            r_start_cap  <= w_start_next;
            r_end_cap    <= w_end_next;
            r_locked     <= (w_state_next == ST_LOCKED);
            r_active     <= (w_state_next == ST_LOCKED) && (w_x_next < c_H_ACTIVE)
                            && (w_y_next < c_V_ACTIVE);
            r_sync_err   <= (r_state == ST_LOCKED) && w_mismatch;
            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                r_plat_valid <= w_found_next;
                if (w_found_next) begin
                    r_plat_start <= w_start_next;
                    r_plat_end   <= w_end_next;
                end
            end
        end
    end

    assign pix_x      = r_x;
    assign pix_y      = r_y;
    assign active     = r_active;
    assign locked     = r_locked;
    assign sync_err   = r_sync_err;
    assign frame_done = r_frame_done;
    assign plat_start = r_plat_start;
    assign plat_end   = r_plat_end;
    assign plat_valid = r_plat_valid;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vga_sync_monitor                                          |
// | Description : Directed bench for vga_sync_monitor on a reduced 32x16       |
// |               raster (16x12 active). A behavioural sync/colour generator   |
// |               drives the pins; the bench tracks the pixel shown to the DUT |
// |               sample stage and checks lock, band decode, errors, reset.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vga_sync_monitor;

    localparam int HA  = 16;
    localparam int HT  = 32;
    localparam int HSS = 20;
    localparam int HSE = 26;
    localparam int VA  = 12;
    localparam int VT  = 16;
    localparam int VSS = 13;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic [2:0] rgb_in = 3'd0;
    logic [9:0] pix_x, pix_y, plat_start, plat_end;
    logic       active, locked, sync_err, frame_done, plat_valid;

    vga_sync_monitor #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
        .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .LOCK_FRAMES(2),
        .PLAT_RGB(3'b100)
    ) dut (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb_in(rgb_in), .pix_x(pix_x), .pix_y(pix_y), .active(active),
        .locked(locked), .sync_err(sync_err), .frame_done(frame_done),
        .plat_start(plat_start), .plat_end(plat_end), .plat_valid(plat_valid)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    // Generator state and knobs
    int gx = 0, gy = 0, ps = 3, pe = 6, delay_line = -1, fx = -1, fy = -1;
    // Pixel whose pins were presented before the latest edge
    int px = 0, py = 0;
    int vf_count = 0, vf_base = 0;
    int se_count = 0, se_px = -1, se_py = -1;
    int lock_events = 0, lock_vf = 0, lock_px = -1, lock_py = -1;
    int fd_count = 0, pos_bad = 0, plat_bad = 0, pix_bad = 0;
    int exp_start = 0, exp_end = 0, exp_valid = 0;
    logic prev_locked = 1'b0;
    logic rst_edge;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic drive_pins();
        int hs_lo;
        hs_lo    = HSS + ((gy == delay_line) ? 3 : 0);
        hsync_in = !(gx >= hs_lo && gx < HSE);
        vsync_in = !(gy == VSS || gy == VSS + 1);
        if (gx < HA && gy < VA) begin
            if (gx == fx && gy == fy)       rgb_in = 3'b011;
            else if (gy >= ps && gy < pe)   rgb_in = 3'b100;
            else                            rgb_in = 3'b001;
        end else begin
            rgb_in = 3'd0;
        end
    endtask

    task automatic tick();
        rst_edge = reset;
        @(posedge clk);
        #1;
        px = gx;
        py = gy;
        if (!rst_edge) begin
            if (px == 0 && py == VSS) vf_count++;
            if (sync_err) begin
                se_count++;
                se_px = px;
                se_py = py;
            end
            if (locked && !prev_locked) begin
                lock_events++;
                lock_vf = vf_count;
                lock_px = px;
                lock_py = py;
            end
            if (locked) begin
                if (pix_x !== 10'(px) || pix_y !== 10'(py) || active !== (px < HA && py < VA))
                    pix_bad++;
            end else if (active !== 1'b0) begin
                pix_bad++;
            end
            if (frame_done) begin
                fd_count++;
                if (px != HA || py != VA - 1) pos_bad++;
                if (plat_start !== 10'(exp_start) || plat_end !== 10'(exp_end)
                    || plat_valid !== exp_valid[0])
                    plat_bad++;
            end
        end
        prev_locked = locked;
        if (gx == HT - 1) begin
            gx = 0;
            if (gy == delay_line) delay_line = -1;
            gy = (gy == VT - 1) ? 0 : gy + 1;
        end else begin
            gx++;
        end
        drive_pins();
    endtask

    task automatic wait_frames(input int n);
        int target;
        target = fd_count + n;
        for (int i = 0; i < (n + 1) * HT * VT && fd_count < target; i++) tick();
        check("frame_done_count", fd_count, target);
    endtask

    task automatic wait_lock();
        int target;
        target = lock_events + 1;
        for (int i = 0; i < 5 * HT * VT && lock_events < target; i++) tick();
        check("lock_reached", lock_events, target);
    endtask

    task automatic wait_err();
        int target;
        target = se_count + 1;
        for (int i = 0; i < 2 * HT * VT && se_count < target; i++) tick();
        check("sync_err_seen", se_count, target);
    endtask

    initial begin
        drive_pins();
        reset = 1'b1;
        repeat (3) tick();
        check("rst_pix", {pix_x, pix_y}, 0);
        check("rst_flags", {active, locked, sync_err, frame_done, plat_valid}, 0);
        check("rst_plat", {plat_start, plat_end}, 0);
        reset = 1'b0;
        vf_base = vf_count;

        // Band rows 3..5 -> start 3, end 6
        ps = 3; pe = 6; exp_start = 3; exp_end = 6; exp_valid = 1;
        wait_lock();
        check("lockA_vsync_falls", lock_vf - vf_base, 3);
        check("lockA_pos", lock_px * 1000 + lock_py, 1013);
        wait_frames(3);
        check("A_start", plat_start, 3);
        check("A_end", plat_end, 6);
        check("A_valid", plat_valid, 1);

        // Empty band: invalid, previous values held
        ps = 8; pe = 8; exp_valid = 0;
        wait_frames(2);
        check("B_valid", plat_valid, 0);
        check("B_hold", {plat_start, plat_end}, {10'd3, 10'd6});

        // Band runs into the last active row
        ps = 9; pe = 20; exp_start = 9; exp_end = 12; exp_valid = 1;
        wait_frames(2);
        check("C_plat", {plat_start, plat_end, plat_valid}, {10'd9, 10'd12, 1'b1});

        // One off-colour pixel breaks row 4
        ps = 3; pe = 6; fx = 5; fy = 4; exp_start = 3; exp_end = 4; exp_valid = 1;
        wait_frames(2);
        check("D_plat", {plat_start, plat_end, plat_valid}, {10'd3, 10'd4, 1'b1});
        fx = -1; fy = -1;
        check("fd_position", pos_bad, 0);
        check("plat_every_frame", plat_bad, 0);
        check("pix_tracking", pix_bad, 0);
        check("no_sync_err_yet", se_count, 0);

        // Late hsync fall on row 5 while locked
        delay_line = 5;
        wait_err();
        check("E_err_pos", se_px * 1000 + se_py, 22005);
        check("E_unlocked", locked, 0);
        check("E_plat_kept", {plat_start, plat_end, plat_valid}, {10'd3, 10'd4, 1'b1});
        vf_base = vf_count;
        tick();
        check("E_err_one_clk", sync_err, 0);
        exp_start = 3; exp_end = 6; exp_valid = 1;
        wait_lock();
        check("E_relock_vsync_falls", lock_vf - vf_base, 3);
        check("E_relock_pos", lock_px * 1000 + lock_py, 1013);
        wait_frames(1);
        check("E_plat", {plat_start, plat_end, plat_valid}, {10'd3, 10'd6, 1'b1});
        check("E_single_err", se_count, 1);

        // Reset in the middle of a locked frame at (10,5)
        for (int i = 0; i < HT * VT + 1 && !(px == 10 && py == 5); i++) tick();
        check("F_reached_pixel", px * 1000 + py, 10005);
        reset = 1'b1;
        tick();
        check("F_rst_pix", {pix_x, pix_y}, 0);
        check("F_rst_flags", {active, locked, sync_err, frame_done, plat_valid}, 0);
        check("F_rst_plat", {plat_start, plat_end}, 0);
        reset = 1'b0;
        vf_base = vf_count;
        wait_lock();
        check("F_relock_vsync_falls", lock_vf - vf_base, 3);
        check("F_relock_pos", lock_px * 1000 + lock_py, 1013);
        wait_frames(1);
        check("F_plat", {plat_start, plat_end, plat_valid}, {10'd3, 10'd6, 1'b1});
        check("final_pix_tracking", pix_bad, 0);
        check("final_fd_position", pos_bad, 0);
        check("final_plat_every_frame", plat_bad, 0);
        check("final_err_count", se_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
